// File: rtl/audio_sigma_delta_out_if.sv
// Bus bundle for the audio output stage.
//   master : the block feeding the stage (FM sample, speaker, gain controls, clip clear)
//   slave  : audio_sigma_delta_out itself (tick strobe, PCM, mute flag, clip count, DAC pin)
// Port summary:
//   fm_sample   [7:0] signed FM sample, taken only on sample_tick
//   speaker           PC-speaker level
//   speaker_en        1 = include speaker in the mix
//   enable            1 = ramp gain up to volume, 0 = ramp down to mute
//   volume      [3:0] target gain, gain = volume/8
//   clip_clr          clears clip_cnt
//   sample_tick       one-cycle strobe per sample period
//   pcm         [8:0] signed PCM value feeding the modulator
//   muted             1 while the gain FSM sits in MUTED
//   clip_cnt    [7:0] saturating count of saturated samples
//   dac_out           1-bit sigma-delta bitstream
interface audio_sigma_delta_out_if;
  logic signed [7:0] fm_sample;
  logic              speaker;
  logic              speaker_en;
  logic              enable;
  logic        [3:0] volume;
  logic              clip_clr;
  logic              sample_tick;
  logic signed [8:0] pcm;
  logic              muted;
  logic        [7:0] clip_cnt;
  logic              dac_out;

  modport master (
    output fm_sample, speaker, speaker_en, enable, volume, clip_clr,
    input  sample_tick, pcm, muted, clip_cnt, dac_out
  );

  modport slave (
    input  fm_sample, speaker, speaker_en, enable, volume, clip_clr,
    output sample_tick, pcm, muted, clip_cnt, dac_out
  );
endinterface

// File: rtl/audio_sigma_delta_out.sv
// Final audio output stage: resamples the FM sample and PC-speaker bit on a fixed
// tick, mixes them, applies a click-free ramped gain, saturates to 9 bits and drives
// a first-order 1-bit sigma-delta DAC pin (board RC filter follows).
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    audio_sigma_delta_out_if.slave (see interface file for signal list)
// Parameters:
//   SAMPLE_DIV  clk cycles per sample tick (>= 4)
//   SPK_LEVEL   speaker amplitude, applied as +/-SPK_LEVEL (0..127)
module audio_sigma_delta_out #(
  parameter int unsigned SAMPLE_DIV = 1024,
  parameter int          SPK_LEVEL  = 48
) (
  input logic                     clk,
  input logic                     reset,
  audio_sigma_delta_out_if.slave  bus
);

  localparam int unsigned        DIV_W    = $clog2(SAMPLE_DIV);
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic signed [7:0]  SPK_POS  = 8'(SPK_LEVEL);
  localparam logic signed [7:0]  SPK_NEG  = 8'(-SPK_LEVEL);
  localparam logic signed [14:0] S_MAX    = 15'sd255;
  localparam logic signed [14:0] S_MIN    = -15'sd256;

  typedef enum logic [1:0] {MUTED, RAMP_UP, ACTIVE, RAMP_DOWN} state_t;

  state_t            state;
  logic [DIV_W-1:0]  div;
  logic              sample_tick;
  logic              tick_d;       // cycle after the tick: samp_r/spk_r/g are fresh
  logic signed [7:0] samp_r;
  logic signed [7:0] spk_r;
  logic        [3:0] g;
  logic              muted;
  logic signed [8:0] pcm;
  logic        [7:0] clip_cnt;
  logic        [8:0] acc;
  logic              dac_out;

  // Mix / gain / saturate datapath (operands are all registers).
  logic signed [9:0]  mix;
  logic signed [14:0] prod;
  logic signed [14:0] s;
  logic               sat_hi;
  logic               sat_lo;
  logic signed [8:0]  pcm_next;

  assign mix      = 10'(samp_r) + 10'(spk_r);
  assign prod     = 15'(mix) * 15'($signed({1'b0, g}));
  assign s        = prod >>> 3;
  assign sat_hi   = (s > S_MAX);
  assign sat_lo   = (s < S_MIN);
  assign pcm_next = sat_hi ? 9'sd255 : (sat_lo ? -9'sd256 : s[8:0]);

  // Offset-binary modulator input: pcm + 256 is just pcm with the sign bit inverted.
  logic [8:0] u;
  logic [9:0] acc_sum;

  assign u       = {~pcm[8], pcm[7:0]};
  assign acc_sum = {1'b0, acc} + {1'b0, u};

  // One gain step toward volume, and one step toward zero.
  logic [3:0] g_toward;
  logic [3:0] g_dec;

  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    g_toward = g;
    if (g < bus.volume)      g_toward = g + 4'd1;
    else if (g > bus.volume) g_toward = g - 4'd1;
    g_dec = (g == 4'd0) ? 4'd0 : g - 4'd1;
  end

  // Gain FSM, evaluated only on the sample tick. muted is registered alongside state.
  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments; reset is synchronous and every register gets a value.
    if (reset) begin
      state <= MUTED;
      g     <= 4'd0;
      muted <= 1'b1;
    end else if (sample_tick) begin
      case (state)
        MUTED: begin
          g <= 4'd0;
          if (bus.enable) begin
            state <= RAMP_UP;
            muted <= 1'b0;
          end
        end
        RAMP_UP: begin
          if (!bus.enable) begin
            state <= RAMP_DOWN;
          end else begin
            g <= g_toward;
            if (g_toward == bus.volume) state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (!bus.enable) state <= RAMP_DOWN;
          else             g     <= g_toward;
        end
        RAMP_DOWN: begin
          // Re-enable resumes the ramp from the current gain, no jump.
          if (bus.enable) begin
            state <= RAMP_UP;
          end else begin
            g <= g_dec;
            if (g_dec == 4'd0) begin
              state <= MUTED;
              muted <= 1'b1;
            end
          end
        end
        default: begin
          state <= MUTED;
          g     <= 4'd0;
          muted <= 1'b1;
        end
      endcase
    end
  end

  // Divider, sample registers, PCM, clip counter and modulator.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      sample_tick <= 1'b0;
      tick_d      <= 1'b0;
      samp_r      <= '0;
      spk_r       <= '0;
      pcm         <= '0;
      clip_cnt    <= '0;
      acc         <= '0;
      dac_out     <= 1'b0;
    end else begin
      div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
      sample_tick <= (div == DIV_LAST);
      tick_d      <= sample_tick;

      if (sample_tick) begin
        samp_r <= bus.fm_sample;
        spk_r  <= bus.speaker_en ? (bus.speaker ? SPK_POS : SPK_NEG) : 8'sd0;
      end

      if (tick_d) pcm <= pcm_next;

      // Clear has priority over a coincident saturation.
      if (bus.clip_clr)
        clip_cnt <= '0;
      else if (tick_d && (sat_hi || sat_lo) && (clip_cnt != 8'hFF))
        clip_cnt <= clip_cnt + 8'd1;

      {dac_out, acc} <= acc_sum;
    end
  end

  assign bus.sample_tick = sample_tick;
  assign bus.pcm         = pcm;
  assign bus.muted       = muted;
  assign bus.clip_cnt    = clip_cnt;
  assign bus.dac_out     = dac_out;

endmodule

// File: tb/tb_audio_sigma_delta_out.sv
module tb_audio_sigma_delta_out;

  localparam int DIV = 8;
  localparam int SPK = 48;

  localparam int MD_MUTED  = 0;
  localparam int MD_UP     = 1;
  localparam int MD_ACTIVE = 2;
  localparam int MD_DOWN   = 3;

  logic clk = 1'b0;
  logic reset;

  audio_sigma_delta_out_if bus();

  audio_sigma_delta_out #(.SAMPLE_DIV(DIV), .SPK_LEVEL(SPK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // ---------------- Behavioural model ----------------
  // Time is an edge count since reset; the tick is visible after every DIV-th edge.
  // Audio values are plain integers; the gain is a mode plus an integer level.
  int m_k, m_samp, m_spk, m_g, m_mode, m_pcm, m_clip, m_acc, m_sum, m_s;
  bit m_tick, m_tickd, m_muted, m_dac, m_sat;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0; m_tick = 0; m_tickd = 0; m_samp = 0; m_spk = 0; m_g = 0;
      m_mode = MD_MUTED; m_muted = 1; m_pcm = 0; m_clip = 0; m_acc = 0; m_dac = 0;
    end else begin
      // Modulator: carry out of acc + (pcm + 256) modulo 512.
      m_sum = m_acc + m_pcm + 256;
      m_dac = (m_sum >= 512);
      m_acc = m_sum % 512;
      // PCM updates the cycle after a tick, from the values taken at the tick.
      m_sat = 0;
      if (m_tickd) begin
        m_s = ((m_samp + m_spk) * m_g) >>> 3;
        if (m_s > 255)       begin m_pcm = 255;  m_sat = 1; end
        else if (m_s < -256) begin m_pcm = -256; m_sat = 1; end
        else                       m_pcm = m_s;
      end
      if (bus.clip_clr)              m_clip = 0;
      else if (m_sat && m_clip < 255) m_clip++;
      if (m_tick) begin
        m_samp = $signed(bus.fm_sample);
        m_spk  = bus.speaker_en ? (bus.speaker ? SPK : -SPK) : 0;
        case (m_mode)
          MD_MUTED: if (bus.enable) m_mode = MD_UP;
          MD_UP: begin
            if (!bus.enable) m_mode = MD_DOWN;
            else begin
              m_g = m_g + (int'(bus.volume) > m_g) - (int'(bus.volume) < m_g);
              if (m_g == int'(bus.volume)) m_mode = MD_ACTIVE;
            end
          end
          MD_ACTIVE: begin
            if (!bus.enable) m_mode = MD_DOWN;
            else m_g = m_g + (int'(bus.volume) > m_g) - (int'(bus.volume) < m_g);
          end
          default: begin
            if (bus.enable) m_mode = MD_UP;
            else begin
              if (m_g > 0) m_g--;
              if (m_g == 0) m_mode = MD_MUTED;
            end
          end
        endcase
        m_muted = (m_mode == MD_MUTED);
      end
      m_tickd = m_tick;
      m_k++;
      m_tick = (m_k % DIV == 0);
    end
    m_valid = 1'b1;
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("sample_tick", bus.sample_tick, m_tick);
      check("pcm",         $signed(bus.pcm), m_pcm);
      check("muted",       bus.muted, m_muted);
      check("clip_cnt",    bus.clip_cnt, m_clip);
      check("dac_out",     bus.dac_out, m_dac);
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 2 * DIV + 2; i++) begin
      @(negedge clk);
      if (bus.sample_tick) begin seen = 1; break; end
    end
    if (!seen) timeout("wait_tick");
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  task automatic count_dac(input int n, output int cnt);
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      cnt += int'(bus.dac_out);
    end
  endtask

  task automatic wait_gain(input int level, input string name);
    bit hit = 0;
    for (int i = 0; i < 40; i++) begin
      wait_tick();
      @(negedge clk);
      if (m_g == level) begin hit = 1; break; end
    end
    if (!hit) timeout(name);
  endtask

  task automatic wait_mode(input int mode, input string name);
    bit hit = 0;
    for (int i = 0; i < 40; i++) begin
      wait_tick();
      @(negedge clk);
      if (m_mode == mode) begin hit = 1; break; end
    end
    if (!hit) timeout(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- Directed + random stimulus ----------------
  initial begin
    int n, cnt;
    bit seen;

    reset = 1'b1;
    bus.fm_sample  = 8'h40;
    bus.speaker    = 1'b0;
    bus.speaker_en = 1'b0;
    bus.enable     = 1'b1;
    bus.volume     = 4'd8;
    bus.clip_clr   = 1'b0;
    cycles(3);

    // First tick lands 8 edges after reset release; still muted until then.
    reset = 1'b0;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n++;
      if (i == 0) check("muted_at_start", bus.muted, 1);
      if (bus.sample_tick) begin seen = 1; break; end
    end
    if (!seen) timeout("first_tick");
    check("first_tick_delay", n, 8);
    @(negedge clk);
    check("muted_after_tick1", bus.muted, 0);

    // 0x40 at gain 8/8 -> pcm 64 -> 320/512 density.
    wait_ticks(10);
    cycles(2);
    check("pcm_64", $signed(bus.pcm), 64);
    count_dac(512, cnt);
    check("dac_density_320", cnt, 320);

    // Mute ramp from gain 8; pcm 0 gives exactly half density.
    bus.enable = 1'b0;
    wait_ticks(9);
    cycles(2);
    check("muted_after_ramp", bus.muted, 1);
    check("pcm_muted", $signed(bus.pcm), 0);
    cycles(1);
    count_dac(512, cnt);
    check("dac_density_256", cnt, 256);

    // Re-enable partway down the ramp: ramp up resumes from gain 3.
    bus.enable = 1'b1;
    wait_mode(MD_ACTIVE, "reach_active");
    bus.enable = 1'b0;
    wait_gain(3, "reach_gain3");
    bus.enable = 1'b1;
    wait_ticks(2);
    cycles(2);
    check("pcm_resume_g4", $signed(bus.pcm), 32);

    // Positive overload: 127 + 48 = 175, *15 >> 3 = 328 -> 255; clip counter saturates.
    bus.fm_sample  = 8'h7F;
    bus.speaker_en = 1'b1;
    bus.speaker    = 1'b1;
    bus.volume     = 4'd15;
    wait_ticks(14);
    cycles(2);
    check("pcm_clip_hi", $signed(bus.pcm), 255);
    wait_ticks(260);
    check("clip_cnt_sat", bus.clip_cnt, 255);
    bus.clip_clr = 1'b1;
    @(negedge clk);
    bus.clip_clr = 1'b0;
    check("clip_cnt_clr", bus.clip_cnt, 0);
    // Clear held across saturating samples wins every time.
    bus.clip_clr = 1'b1;
    cycles(2 * DIV);
    bus.clip_clr = 1'b0;
    check("clip_clr_wins", bus.clip_cnt, 0);

    // -128 at gain 15 -> -240, inside range.
    bus.fm_sample  = 8'h80;
    bus.speaker_en = 1'b0;
    wait_ticks(2);
    cycles(2);
    check("pcm_neg240", $signed(bus.pcm), -240);
    bus.clip_clr = 1'b1;
    @(negedge clk);
    bus.clip_clr = 1'b0;
    wait_ticks(3);
    cycles(2);
    check("no_clip_neg240", bus.clip_cnt, 0);

    // -128 - 48 = -176, *15 >> 3 = -330 -> -256, DAC stuck low.
    bus.speaker_en = 1'b1;
    bus.speaker    = 1'b0;
    wait_ticks(2);
    cycles(2);
    check("pcm_clip_lo", $signed(bus.pcm), -256);
    count_dac(64, cnt);
    check("dac_stuck_low", cnt, 0);

    // Reset mid-ramp at gain 5.
    bus.fm_sample  = 8'h40;
    bus.speaker_en = 1'b0;
    bus.enable     = 1'b0;
    wait_mode(MD_MUTED, "reach_muted");
    bus.enable = 1'b1;
    wait_gain(5, "reach_gain5");
    cycles(2);
    check("pcm_before_reset", $signed(bus.pcm), 40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_pcm", $signed(bus.pcm), 0);
    check("rst_muted", bus.muted, 1);
    check("rst_dac", bus.dac_out, 0);
    check("rst_clip", bus.clip_cnt, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      bus.fm_sample = 8'($urandom);
      if ($urandom_range(0, 39) == 0) bus.enable     = ~bus.enable;
      if ($urandom_range(0, 59) == 0) bus.volume     = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 49) == 0) bus.speaker_en = ~bus.speaker_en;
      if ($urandom_range(0, 7)  == 0) bus.speaker    = ~bus.speaker;
      bus.clip_clr = ($urandom_range(0, 63) == 0);
      reset        = ($urandom_range(0, 1499) == 0);
    end
    reset        = 1'b0;
    bus.clip_clr = 1'b0;
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
